apb_mem_slave_p: RTL and testbench
==================================

# apb_mem_slave_p

Parametrised APB4 memory-mapped slave: a word-addressed register/memory bank with byte-lane write strobes, a programmable number of wait states, and error signalling (PSLVERR) for out-of-range or misaligned addresses. It is the next-generation replacement for the fixed-width zero-wait APB slave. It sits on the APB bus behind the existing APB master, which drives PSEL/PENABLE/PADDR/PWRITE/PWDATA/PSTRB.

## Interface
- ADDR_WIDTH, 12: PADDR width in bits.
- DATA_WIDTH, 32: PWDATA/PRDATA width; legal values 8, 16, 32, 64.
- DEPTH, 256: number of DATA_WIDTH words; must be at most 2^(ADDR_WIDTH - log2(DATA_WIDTH/8)).
- WAIT_STATES, 0: extra access-phase cycles before PREADY is asserted; legal range 0..15.

Ports:
- PCLK  in  1  bus clock; all state updates on its rising edge.
- PRESETn  in  1  reset; one clock, asynchronous, active-low.
- PSEL  in  1  slave select.
- PENABLE  in  1  access-phase indicator.
- PADDR  in  ADDR_WIDTH  byte address.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  byte-lane write enables.
- PRDATA  out  DATA_WIDTH  read data; 0 unless a read is completing.
- PREADY  out  1  transfer-complete.
- PSLVERR  out  1  error; valid only when PREADY=1.

## Operation
- Word index is PADDR[ADDR_WIDTH-1:AL], where AL = log2(DATA_WIDTH/8).
- An address is misaligned if PADDR[AL-1:0] != 0. AL=0 means never misaligned.
- An address is out of range if the word index >= DEPTH.
- Either condition is an error. An error transfer never modifies memory and returns PRDATA=0.
- FSM states:
  - IDLE: waiting for a setup phase.
  - ACCESS: transfer in progress, waiting for completion.
- IDLE -> ACCESS on a setup cycle (PSEL=1, PENABLE=0). On that edge the slave:
  - latches the address, direction and error flag;
  - loads the wait counter with WAIT_STATES;
  - latches mem[index] into the read register (0 on error).
- ACCESS with PSEL=1, PENABLE=1, counter>0: decrement the counter and hold PREADY=0.
- ACCESS with PSEL=1, PENABLE=1, counter=0: the transfer completes.
  - PREADY=1; PSLVERR=latched error flag.
  - PRDATA=read register if the transfer is a read.
  - For a non-error write, at this edge each byte lane i with PSTRB[i]=1 is written from PWDATA; lanes with PSTRB[i]=0 keep their old value.
  - Next state: IDLE.
- PSTRB is ignored on reads. A write with PSTRB=0 completes normally and changes nothing.
- ACCESS with PSEL=0 (master abort): return to IDLE, no write, outputs stay 0.
- Protocol violation (PSEL=1, PENABLE=1 while in IDLE): respond combinationally with PREADY=1, PSLVERR=1, PRDATA=0, no write. State stays IDLE.
- Back-to-back transfers: a setup cycle immediately after a completing cycle is accepted normally.

## Timing
- Reset values:
  - PRDATA=0, PREADY=0, PSLVERR=0;
  - state=IDLE, wait counter=0, read register=0;
  - every memory word = 0.
- Transfer length is 2+WAIT_STATES cycles: 1 setup cycle plus 1+WAIT_STATES access cycles. PREADY is high only in the final access cycle.
- PREADY, PSLVERR and PRDATA are combinational from registered state AND (PSEL & PENABLE). All three are 0 whenever PSEL=0 or PENABLE=0.
- Write data becomes visible to a following read at that read's setup edge. Read-after-write to the same address returns the new data with no hazard.
- Reset mid-transfer (PRESETn falls at any point): outputs go to 0 immediately (asynchronously). The in-flight write is not committed and the FSM is in IDLE when PRESETn rises. The first rising PCLK edge with PRESETn=1 may accept a setup cycle.

## Test plan
Parameters for all scenarios: DATA_WIDTH=32, DEPTH=256, ADDR_WIDTH=12, with WAIT_STATES=0 unless noted.
- Reset/readback: release reset, then read 0x000 and 0x3FC -> PRDATA=0x00000000, PSLVERR=0, PREADY high in cycle 2 of each transfer.
- Full write/read: write 0xDEADBEEF to 0x010 with PSTRB=4'hF, then read 0x010 -> 0xDEADBEEF. Write 0x11223344 to 0x3FC, then read it back -> 0x11223344.
- Byte strobes: 0x020 holds 0xAABBCCDD; write 0x11223344 with PSTRB=4'b0101; read 0x020 -> 0xAA22CC44.
- Errors:
  - write 0x12345678 to 0x400 (out of range) -> PSLVERR=1 on the PREADY cycle;
  - read 0x013 (misaligned) -> PSLVERR=1, PRDATA=0;
  - existing contents unchanged.
- Wait states: with WAIT_STATES=3, write then read 0x040 -> PREADY=0 for 3 access cycles and high on the 4th (5 cycles per transfer); data is correct.
- Abort/reset: with WAIT_STATES=3, start a write of 0xCAFEF00D to 0x080, then either drop PSEL after one access cycle, or pull PRESETn low mid-transfer -> outputs 0, and a subsequent read of 0x080 returns its prior value (0 after reset).

Source files
------------

// File: rtl/apb_mem_slave_p.sv
// APB4 memory slave: word-addressed bank with byte strobes, programmable wait
// states and PSLVERR on out-of-range or misaligned accesses.
module apb_mem_slave_p #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic [0:0]              dbg_state
);

  // Handshake: a transfer is a setup cycle (PSEL=1, PENABLE=0) followed by
  // access cycles (PSEL=1, PENABLE=1); it completes on the access cycle where
  // PREADY=1, and PSLVERR/PRDATA are meaningful only in that cycle.

  localparam int NB = DATA_WIDTH / 8;
  localparam int AL = $clog2(NB);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << AL) - 1);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  logic [0:0]            state;
  logic [3:0]            wcnt;
  logic [IW-1:0]         addr_q;
  logic                  write_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [IW-1:0]         mem_idx;
  logic                  addr_err;
  logic                  setup;
  logic                  access;
  logic                  complete;
  logic                  proto_err;
  logic                  do_write;

  assign word_idx = PADDR >> AL;
  assign mem_idx  = word_idx[IW-1:0];
  // Widen by one bit so DEPTH == 2^(ADDR_WIDTH-AL) still compares correctly.
  assign addr_err = (|(PADDR & ALIGN_MASK)) ||
                    ((ADDR_WIDTH+1)'(word_idx) >= (ADDR_WIDTH+1)'(DEPTH));

  assign setup     = PSEL & ~PENABLE;
  assign access    = PSEL & PENABLE;
  assign complete  = access && (state == S_ACCESS) && (wcnt == 4'd0);
  assign proto_err = access && (state == S_IDLE);
  assign do_write  = complete && write_q && !err_q;

  // Gated by PRESETn so outputs drop the moment reset asserts.
  always_comb begin
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = '0;
    if (PRESETn) begin
      PREADY  = complete | proto_err;
      PSLVERR = (complete & err_q) | proto_err;
      if (complete && !write_q)
        PRDATA = rdata_q;
    end
  end

  assign dbg_state = state;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= S_IDLE;
      wcnt    <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (setup) begin
      state   <= S_ACCESS;
      wcnt    <= WS;
      addr_q  <= mem_idx;
      write_q <= PWRITE;
      err_q   <= addr_err;
      rdata_q <= addr_err ? '0 : mem[mem_idx];
    end else if (state == S_ACCESS) begin
      if (!PSEL) begin
        state <= S_IDLE;
      end else if (wcnt != 4'd0) begin
        wcnt <= wcnt - 4'd1;
      end else begin
        state <= S_IDLE;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (do_write) begin
      for (int b = 0; b < NB; b++)
        if (PSTRB[b])
          mem[addr_q][8*b +: 8] <= PWDATA[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_apb_mem_slave_p.sv
// Directed bench for apb_mem_slave_p: one instance with zero wait states and
// one with three, sharing the bus wires but with separate PSEL and reset.
module tb_apb_mem_slave_p;

  logic        clk;
  logic        rst_n0, rst_n3;
  logic        psel0, psel3, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3, pslverr0, pslverr3;
  logic [0:0]  st0, st3;
  bit          sel3;

  int n_checks = 0;
  int n_fail   = 0;

  apb_mem_slave_p #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .PCLK(clk), .PRESETn(rst_n0), .PSEL(psel0), .PENABLE(penable), .PADDR(paddr),
    .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata0),
    .PREADY(pready0), .PSLVERR(pslverr0), .dbg_state(st0)
  );

  apb_mem_slave_p #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(3)) u_ws3 (
    .PCLK(clk), .PRESETn(rst_n3), .PSEL(psel3), .PENABLE(penable), .PADDR(paddr),
    .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata3),
    .PREADY(pready3), .PSLVERR(pslverr3), .dbg_state(st3)
  );

  wire [31:0] prdata  = sel3 ? prdata3  : prdata0;
  wire        pready  = sel3 ? pready3  : pready0;
  wire        pslverr = sel3 ? pslverr3 : pslverr0;
  wire [0:0]  st      = sel3 ? st3      : st0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_psel(input logic v);
    if (sel3) psel3 = v; else psel0 = v;
  endtask

  task automatic bus_idle();
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
  endtask

  // Called #1 after a rising edge; leaves the bus idle at the same time step so
  // a following call is a back-to-back setup.
  task automatic apb_xfer(input bit w, input logic [11:0] a, input logic [31:0] wd,
                          input logic [3:0] sb, output logic [31:0] rd,
                          output logic err, output int cyc);
    bit done = 0;
    set_psel(1'b1); penable = 1'b0; pwrite = w; paddr = a; pwdata = wd; pstrb = sb;
    rd = '0; err = 1'b0; cyc = 0;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int c = 2; c < 22 && !done; c++) begin
      @(negedge clk);
      if (pready) begin
        rd = prdata; err = pslverr; cyc = c; done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL xfer_timeout addr 0x%0h: no PREADY within 20 cycles", a);
    end
    bus_idle();
  endtask

  task automatic do_write(input string tag, input logic [11:0] a, input logic [31:0] wd,
                          input logic [3:0] sb, input logic exp_err, input int exp_cyc);
    logic [31:0] rd; logic err; int cyc;
    apb_xfer(1'b1, a, wd, sb, rd, err, cyc);
    check({tag, "_err"}, 64'(err), 64'(exp_err));
    check({tag, "_cyc"}, 64'(cyc), 64'(exp_cyc));
    check({tag, "_prdata0"}, 64'(rd), 64'h0);
  endtask

  task automatic do_read(input string tag, input logic [11:0] a, input logic [31:0] exp_d,
                         input logic exp_err, input int exp_cyc);
    logic [31:0] rd; logic err; int cyc;
    apb_xfer(1'b0, a, 32'h0, 4'hF, rd, err, cyc);
    check({tag, "_data"}, 64'(rd), 64'(exp_d));
    check({tag, "_err"}, 64'(err), 64'(exp_err));
    check({tag, "_cyc"}, 64'(cyc), 64'(exp_cyc));
  endtask

  initial begin
    sel3 = 0;
    bus_idle();
    rst_n0 = 1'b0; rst_n3 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n0 = 1'b1; rst_n3 = 1'b1;
    @(posedge clk); #1;

    // reset state
    check("rst_pready", 64'(pready), 64'h0);
    check("rst_pslverr", 64'(pslverr), 64'h0);
    check("rst_prdata", 64'(prdata), 64'h0);
    check("rst_state", 64'(st), 64'h0);

    // readback after reset
    do_read("rd_000", 12'h000, 32'h0, 1'b0, 2);
    do_read("rd_3fc", 12'h3FC, 32'h0, 1'b0, 2);

    // full word write/read, back-to-back
    do_write("wr_010", 12'h010, 32'hDEADBEEF, 4'hF, 1'b0, 2);
    do_read("rd_010", 12'h010, 32'hDEADBEEF, 1'b0, 2);
    do_write("wr_3fc", 12'h3FC, 32'h11223344, 4'hF, 1'b0, 2);
    do_read("rd_3fc_b", 12'h3FC, 32'h11223344, 1'b0, 2);

    // byte strobes
    do_write("wr_020", 12'h020, 32'hAABBCCDD, 4'hF, 1'b0, 2);
    do_write("wr_020_strb", 12'h020, 32'h11223344, 4'b0101, 1'b0, 2);
    do_read("rd_020", 12'h020, 32'hAA22CC44, 1'b0, 2);

    // errors: 0x400 would alias word 0 if range were not checked
    do_write("wr_400_oor", 12'h400, 32'h12345678, 4'hF, 1'b1, 2);
    do_read("rd_000_after_oor", 12'h000, 32'h0, 1'b0, 2);
    do_write("wr_011_mis", 12'h011, 32'h99999999, 4'hF, 1'b1, 2);
    do_read("rd_013_mis", 12'h013, 32'h0, 1'b1, 2);
    do_read("rd_010_keep", 12'h010, 32'hDEADBEEF, 1'b0, 2);

    // zero strobe write changes nothing
    do_write("wr_010_nostrb", 12'h010, 32'h00000000, 4'h0, 1'b0, 2);
    do_read("rd_010_nostrb", 12'h010, 32'hDEADBEEF, 1'b0, 2);

    // protocol violation: access phase straight from IDLE
    psel0 = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h010; pwdata = 32'h0; pstrb = 4'hF;
    #1;
    check("proto_pready", 64'(pready), 64'h1);
    check("proto_pslverr", 64'(pslverr), 64'h1);
    check("proto_prdata", 64'(prdata), 64'h0);
    @(posedge clk); #1;
    check("proto_state", 64'(st), 64'h0);
    bus_idle();
    @(negedge clk);
    check("idle_pready", 64'(pready), 64'h0);
    @(posedge clk); #1;
    do_read("rd_010_proto", 12'h010, 32'hDEADBEEF, 1'b0, 2);

    // wait states
    sel3 = 1;
    do_write("ws_wr_040", 12'h040, 32'h0BADF00D, 4'hF, 1'b0, 5);
    do_read("ws_rd_040", 12'h040, 32'h0BADF00D, 1'b0, 5);
    do_read("ws_rd_401_err", 12'h401, 32'h0, 1'b1, 5);

    // abort: drop PSEL after one access cycle
    do_write("ws_wr_080", 12'h080, 32'h55AA55AA, 4'hF, 1'b0, 5);
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h080; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check("abort_pready_wait", 64'(pready), 64'h0);
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    check("abort_pready", 64'(pready), 64'h0);
    check("abort_prdata", 64'(prdata), 64'h0);
    @(posedge clk); #1;
    check("abort_state", 64'(st), 64'h0);
    do_read("rd_080_abort", 12'h080, 32'h55AA55AA, 1'b0, 5);

    // reset mid-transfer
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h080; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n3 = 1'b0;
    #1;
    check("rst_mid_pready", 64'(pready), 64'h0);
    check("rst_mid_pslverr", 64'(pslverr), 64'h0);
    check("rst_mid_prdata", 64'(prdata), 64'h0);
    check("rst_mid_state", 64'(st), 64'h0);
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk); rst_n3 = 1'b1;
    @(posedge clk); #1;
    do_read("rd_080_rst", 12'h080, 32'h0, 1'b0, 5);

    // other instance untouched by that reset
    sel3 = 0;
    do_read("rd_020_ws0", 12'h020, 32'hAA22CC44, 1'b0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
